// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access mode codes, FSM state encoding and alignment check shared by the LSU
package load_store_unit_pkg;
    localparam int L_S_MODE_W = 3;
    localparam logic [L_S_MODE_W-1:0] L_S_WORD   = 3'd0;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF   = 3'd1;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = 3'd2;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = 3'd3;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = 3'd4;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} ls_state_t;
    function automatic logic misaligned(input logic [L_S_MODE_W-1:0] mode, input logic [1:0] lane);
        return ((mode == L_S_HALF || mode == L_S_HALF_U) && lane[0]) || (mode == L_S_WORD && lane != 2'b00);
    endfunction
endpackage

// File: rtl/load_store_unit_ls_format.sv
// ls_format: byte-lane steering for stores and lane extraction/extension for loads
module ls_format
    import load_store_unit_pkg::*;
(
    input  logic [L_S_MODE_W-1:0] mode,
    input  logic [1:0]            lane,
    input  logic [31:0]           wdata,
    input  logic [31:0]           bus_rdata,
    output logic [3:0]            be,
    output logic [31:0]           bus_wdata,
    output logic [31:0]           rdata
);
    logic       is_byte;
    logic       is_half;
    logic [7:0]  b;
    logic [15:0] h;
    // enables, replicated store data and extended load data all derive from mode and lane
    always_comb begin
        is_byte   = mode == L_S_BYTE || mode == L_S_BYTE_U;
        is_half   = mode == L_S_HALF || mode == L_S_HALF_U;
        b         = bus_rdata[{lane, 3'b000} +: 8];
        h         = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        be        = is_byte ? 4'b0001 << lane : is_half ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        bus_wdata = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
        rdata     = mode == L_S_BYTE   ? {{24{b[7]}}, b}  :
                    mode == L_S_BYTE_U ? {24'b0, b}       :
                    mode == L_S_HALF   ? {{16{h[15]}}, h} :
                    mode == L_S_HALF_U ? {16'b0, h}       : bus_rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store engine issuing one bus access per instruction with pipeline stall
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  addr_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata
);
    ls_state_t             state;
    ls_state_t             state_n;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [L_S_MODE_W-1:0] mode_q;
    logic                  read_q;
    logic                  go;
    logic                  bad;
    logic [3:0]            fmt_be;
    logic [31:0]           fmt_wdata;
    logic [31:0]           fmt_rdata;

    ls_format u_fmt (
        .mode      (mode_q),
        .lane      (addr_q[1:0]),
        .wdata     (wdata_q),
        .bus_rdata (bus_rdata),
        .be        (fmt_be),
        .bus_wdata (fmt_wdata),
        .rdata     (fmt_rdata)
    );

    // next state, stall and bus drive; bus outputs read zero whenever no access is in flight
    always_comb begin
        go          = state == S_IDLE && (mem_read_en || mem_write_en) && !rst;
        bad         = misaligned(l_s_mode, addr[1:0]);
        state_n     = state == S_BUSY ? (bus_ack ? S_DONE : S_BUSY) : (go && !bad) ? S_BUSY : S_IDLE;
        stall       = state == S_BUSY || (go && !bad);
        bus_req     = state == S_BUSY;
        bus_we      = bus_req && !read_q;
        bus_addr    = bus_req ? {addr_q[31:2], 2'b00} : 32'b0;
        bus_be      = bus_req ? fmt_be : 4'b0;
        bus_wdata   = bus_req ? fmt_wdata : 32'b0;
        rdata_valid = state == S_DONE && read_q;
    end

    // state, request latch, error pulse and load result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mode_q   <= '0;
            read_q   <= 1'b0;
            rdata    <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            addr_err <= go && bad;
            if (go && !bad) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                mode_q  <= l_s_mode;
                read_q  <= mem_read_en;
            end
            if (state == S_BUSY && bus_ack && read_q)
                rdata <= fmt_rdata;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors with hand-computed expectations
module tb_load_store_unit;
    import load_store_unit_pkg::*;
    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [L_S_MODE_W-1:0] l_s_mode;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic                  stall;
    logic [31:0]           rdata;
    logic                  rdata_valid;
    logic                  addr_err;
    logic                  bus_req;
    logic                  bus_we;
    logic [31:0]           bus_addr;
    logic [3:0]            bus_be;
    logic [31:0]           bus_wdata;
    logic                  bus_ack;
    logic [31:0]           bus_rdata;
    int n_chk = 0;
    int n_pass = 0;
    int n_stall, n_valid, n_busy;
    logic [3:0]  s_be;
    logic [31:0] s_wd, s_addr, s_rdata;
    logic        s_we;

    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .l_s_mode(l_s_mode), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .addr_err(addr_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic rd, input logic wr, input logic [2:0] mode, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] brd, input int wait_n);
        mem_read_en = rd; mem_write_en = wr; l_s_mode = mode; addr = a; wdata = wd; bus_rdata = brd;
        n_stall = 0; n_valid = 0; n_busy = 0;
        s_be = '0; s_wd = '0; s_addr = '0; s_we = 1'b0; s_rdata = '0;
        for (int c = 0; c < wait_n + 2; c++) begin
            bus_ack = bus_req && n_busy == wait_n - 1;
            #1;
            if (bus_req && n_busy == 0) begin
                s_be = bus_be; s_wd = bus_wdata; s_addr = bus_addr; s_we = bus_we;
            end
            n_stall += int'(stall);
            n_valid += int'(rdata_valid);
            if (rdata_valid) s_rdata = rdata;
            if (bus_req) n_busy++;
            tick();
        end
        mem_read_en = 1'b0; mem_write_en = 1'b0; bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_read_en = 1'b0; mem_write_en = 1'b0; l_s_mode = L_S_WORD;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) tick();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", 32'(bus_be), 0);
        chk("rst_valid", 32'(rdata_valid), 0);
        mem_read_en = 1'b1;
        #1;
        chk("rst_ignores_req", 32'(stall), 0);
        tick();
        chk("rst_no_busy", 32'(bus_req), 0);
        mem_read_en = 1'b0;
        rst = 1'b0;
        tick();

        run(1'b0, 1'b1, L_S_WORD, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        chk("sw_be", 32'(s_be), 32'hF);
        chk("sw_wdata", s_wd, 32'hDEADBEEF);
        chk("sw_we", 32'(s_we), 1);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_stall_cycles", n_stall, 4);
        chk("sw_valid", n_valid, 0);
        chk("sw_busy_cycles", n_busy, 3);
        #1;
        chk("sw_after_idle", 32'(bus_req), 0);

        run(1'b1, 1'b0, L_S_BYTE, 32'h203, 32'h0, 32'h80FF0000, 1);
        chk("lb_be", 32'(s_be), 32'h8);
        chk("lb_addr", s_addr, 32'h200);
        chk("lb_we", 32'(s_we), 0);
        chk("lb_rdata", s_rdata, 32'hFFFFFF80);
        chk("lb_valid", n_valid, 1);
        chk("lb_stall_cycles", n_stall, 2);
        run(1'b1, 1'b0, L_S_BYTE_U, 32'h203, 32'h0, 32'h80FF0000, 1);
        chk("lbu_rdata", s_rdata, 32'h00000080);

        run(1'b0, 1'b1, L_S_HALF, 32'h302, 32'h1234ABCD, 32'h0, 2);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wdata", s_wd, 32'hABCDABCD);
        chk("sh_hold_rdata", rdata, 32'h00000080);
        run(1'b1, 1'b0, L_S_HALF_U, 32'h302, 32'h0, 32'hF00D0000, 1);
        chk("lhu_rdata", s_rdata, 32'h0000F00D);
        run(1'b1, 1'b0, L_S_HALF, 32'h100, 32'h0, 32'h12348001, 1);
        chk("lh_be", 32'(s_be), 32'h3);
        chk("lh_rdata", s_rdata, 32'hFFFF8001);
        run(1'b0, 1'b1, L_S_BYTE, 32'h101, 32'h000000A5, 32'h0, 1);
        chk("sb_be", 32'(s_be), 32'h2);
        chk("sb_wdata", s_wd, 32'hA5A5A5A5);
        run(1'b1, 1'b1, L_S_WORD, 32'h104, 32'h0, 32'h12345678, 1);
        chk("rw_both_is_read", 32'(s_we), 0);
        chk("rw_rdata", s_rdata, 32'h12345678);

        mem_read_en = 1'b1; l_s_mode = L_S_WORD; addr = 32'h101;
        #1;
        chk("lw_mis_stall", 32'(stall), 0);
        tick();
        mem_read_en = 1'b0;
        chk("lw_mis_err", 32'(addr_err), 1);
        chk("lw_mis_no_req", 32'(bus_req), 0);
        tick();
        chk("lw_mis_err_pulse", 32'(addr_err), 0);
        chk("lw_mis_still_idle", 32'(bus_req), 0);
        mem_write_en = 1'b1; l_s_mode = L_S_HALF; addr = 32'h303;
        tick();
        mem_write_en = 1'b0;
        chk("sh_mis_err", 32'(addr_err), 1);
        chk("sh_mis_no_req", 32'(bus_req), 0);
        tick();

        run(1'b1, 1'b0, L_S_WORD, 32'h200, 32'h0, 32'hCAFEF00D, 1);
        chk("b2b_lw_stall", n_stall, 2);
        chk("b2b_lw_rdata", s_rdata, 32'hCAFEF00D);
        run(1'b0, 1'b1, L_S_WORD, 32'h204, 32'h11223344, 32'h0, 1);
        chk("b2b_sw_stall", n_stall, 2);
        chk("b2b_sw_busy", n_busy, 1);
        chk("b2b_sw_addr", s_addr, 32'h204);
        chk("b2b_sw_valid", n_valid, 0);
        chk("b2b_rdata_hold", rdata, 32'hCAFEF00D);
        #1;
        chk("b2b_no_reissue", 32'(bus_req), 0);

        mem_read_en = 1'b1; l_s_mode = L_S_WORD; addr = 32'h400; bus_rdata = 32'h55555555;
        tick();
        mem_read_en = 1'b0;
        chk("rb_busy", 32'(bus_req), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_req_drop", 32'(bus_req), 0);
        bus_ack = 1'b1;
        #1;
        chk("rb_stall", 32'(stall), 0);
        tick();
        bus_ack = 1'b0;
        chk("rb_no_valid", 32'(rdata_valid), 0);
        chk("rb_no_req", 32'(bus_req), 0);
        chk("rb_rdata_clr", rdata, 0);
        tick();
        chk("rb_idle_valid", 32'(rdata_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
